// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port memory arbiter between instruction fetch and load/store requesters
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed dm-over-if priority.
module memory_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_rdata,

  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic             dm_ready,
  output logic             dm_valid,
  output logic [WIDTH-1:0] dm_rdata,

  output logic             memory_read,
  output logic             memory_write,
  output logic [WIDTH-1:0] memory_address,
  output logic [WIDTH-1:0] memory_data_write,
  input  logic [WIDTH-1:0] memory_data_read,

  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  // Counter preload: ACCESS lasts MEM_LATENCY cycles, ending on the cycle where cnt reaches 0.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic             we_reg;
  logic             grant_if;
  logic             grant_dm;
  logic             grant_any;

`ifdef MEM_ARB_RR_EN
  // Set when the fetch side won the last grant, so the data side goes first on the next tie.
  logic last_is_if;

  // Round-robin pick: on a tie, favour the requester that was not served last.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (dm_req && if_req) begin
      grant_dm = last_is_if;
      grant_if = !last_is_if;
    end else begin
      grant_dm = dm_req;
      grant_if = if_req;
    end
  end

  // Remember who won each grant taken in IDLE; resets to fetch so the data side wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_is_if <= 1'b1;
    end else if (state == IDLE && grant_any) begin
      last_is_if <= grant_if;
    end
  end
`else
  // Fixed priority pick: a pending data request always beats a fetch.
  always_comb begin
    grant_dm = dm_req;
    grant_if = if_req && !dm_req;
  end
`endif

  assign grant_any = grant_dm || grant_if;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus ready, strobe and valid decode; ready is combinational in the grant cycle.
  always_comb begin
    state_nxt    = state;
    if_ready     = 1'b0;
    dm_ready     = 1'b0;
    if_valid     = 1'b0;
    dm_valid     = 1'b0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    case (state)
      IDLE: begin
        if_ready = grant_if;
        dm_ready = grant_dm;
        if (grant_any) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        memory_read  = !we_reg;
        memory_write = we_reg;
        if (cnt == '0) begin
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        if_valid  = (owner == OWN_IF);
        dm_valid  = (owner == OWN_DM);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture at the accepting edge, access countdown, and read-data return to the owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      owner     <= OWN_NONE;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm) begin
            addr_reg  <= dm_addr;
            wdata_reg <= dm_wdata;
            we_reg    <= dm_we;
            owner     <= OWN_DM;
            cnt       <= CNT_INIT;
          end else if (grant_if) begin
            addr_reg  <= if_addr;
            we_reg    <= 1'b0;
            owner     <= OWN_IF;
            cnt       <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!we_reg) begin
            if (owner == OWN_DM) begin
              dm_rdata <= memory_data_read;
            end else if (owner == OWN_IF) begin
              if_rdata <= memory_data_read;
            end
          end
        end
        RESPOND: begin
          owner <= OWN_NONE;
        end
        default: begin
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Memory address and write data come straight from the captured request.
  assign memory_address    = addr_reg;
  assign memory_data_write = wdata_reg;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter (directed and randomized)
module tb_memory_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ready, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready, dm_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        memory_read, memory_write, busy;
  logic [31:0] memory_address, memory_data_write, memory_data_read;

  always #5 clk = ~clk;

  memory_arbiter #(.WIDTH(32), .MEM_LATENCY(L), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .memory_read(memory_read), .memory_write(memory_write), .memory_address(memory_address),
    .memory_data_write(memory_data_write), .memory_data_read(memory_data_read), .busy(busy)
  );

  // Environment memory: combinational read, write on the clock edge while the write strobe is high.
  logic [31:0] mem [0:31] = '{default: 32'h0};
  assign memory_data_read = mem[memory_address[4:0]];
  always @(posedge clk) if (memory_write) mem[memory_address[4:0]] <= memory_data_write;

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level reference: a grant at cycle g occupies g+1..g+L for the strobes,
  // g+L+1 for the response, and the arbiter is free again from g+L+2.
  int          cyc = 0;
  bit          act = 0;
  int          g_cyc;
  bit          g_dm, g_we;
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic [31:0] e_if_rdata = 0, e_dm_rdata = 0;
  logic [31:0] ref_mem [0:31] = '{default: 32'h0};
  bit          glog [$];
`ifdef MEM_ARB_RR_EN
  bit          last_if = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: predict, sample at the falling edge, then advance past the next rising edge.
  task automatic step();
    int ph;
    bit gi, gd, acc;
    gi = 0;
    gd = 0;
    ph = act ? cyc - g_cyc : 0;
    if (act && ph >= L + 2) act = 0;
    if (!act) begin
      if (dm_req && if_req) begin
`ifdef MEM_ARB_RR_EN
        gd = last_if;
`else
        gd = 1;
`endif
        gi = !gd;
      end else begin
        gd = dm_req;
        gi = if_req;
      end
      if (gd || gi) begin
        act     = 1;
        g_cyc   = cyc;
        ph      = 0;
        g_dm    = gd;
        g_we    = gd && dm_we;
        g_addr  = gd ? dm_addr : if_addr;
        g_wdata = dm_wdata;
`ifdef MEM_ARB_RR_EN
        last_if = gi;
`endif
        if (g_we) ref_mem[g_addr[4:0]] = g_wdata;
        else      g_rdata = ref_mem[g_addr[4:0]];
        glog.push_back(gd);
      end
    end
    acc = act && ph >= 1 && ph <= L;
    if (act && ph == L + 1 && !g_we) begin
      if (g_dm) e_dm_rdata = g_rdata;
      else      e_if_rdata = g_rdata;
    end
    @(negedge clk);
    chk1("if_ready", if_ready, gi);
    chk1("dm_ready", dm_ready, gd);
    chk1("busy", busy, act && ph >= 1);
    chk1("memory_read", memory_read, acc && !g_we);
    chk1("memory_write", memory_write, acc && g_we);
    chk1("if_valid", if_valid, act && ph == L + 1 && !g_dm);
    chk1("dm_valid", dm_valid, act && ph == L + 1 && g_dm);
    if (acc) chk("memory_address", memory_address, g_addr);
    if (acc && g_we) chk("memory_data_write", memory_data_write, g_wdata);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("dm_rdata", dm_rdata, e_dm_rdata);
    @(posedge clk);
    #1;
    cyc++;
    if (gd) dm_req = 0;
    if (gi) if_req = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n  = 0;
    dm_req = 0;
    if_req = 0;
    @(posedge clk);
    #1;
    rst_n      = 1;
    act        = 0;
    e_if_rdata = 0;
    e_dm_rdata = 0;
`ifdef MEM_ARB_RR_EN
    last_if    = 1;
`endif
    cyc++;
  endtask

  task automatic set_dm(input logic we, input logic [31:0] addr, input logic [31:0] data);
    dm_req   = 1;
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = data;
  endtask

  initial begin
    int eo [4];
    int k;
    rst_n = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_memory_address", memory_address, 32'h0);
    chk("rst_memory_data_write", memory_data_write, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_memory_read", memory_read, 1'b0);
    chk1("rst_memory_write", memory_write, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    @(posedge clk);
    #1;

    set_dm(1, 8, 32'h1234);  run(5);
    set_dm(1, 17, 99);       run(5);
    set_dm(0, 8, 0);         run(5);
    chk("load8_rdata", dm_rdata, 32'h1234);
    if_req = 1; if_addr = 17; run(5);
    chk("fetch17_rdata", if_rdata, 99);

    glog.delete();
    set_dm(0, 17, 0); if_req = 1; if_addr = 8;
    run(10);
    chk("cont_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk1("cont_first_dm", glog[0], 1'b1);
      chk1("cont_second_if", glog[1], 1'b0);
    end
    chk("cont_if_rdata", if_rdata, 32'h1234);

    glog.delete();
    k = 0;
    while (glog.size() < 4 && k < 60) begin
      if (!dm_req) set_dm(0, $urandom_range(0, 31), 0);
      if (!if_req) begin if_req = 1; if_addr = $urandom_range(0, 31); end
      step();
      k++;
    end
    dm_req = 0; if_req = 0;
    run(6);
    chk("rr_grants", glog.size(), 4);
`ifdef MEM_ARB_RR_EN
    eo = '{1, 0, 1, 0};
`else
    eo = '{1, 1, 1, 1};
`endif
    if (glog.size() >= 4)
      for (int i = 0; i < 4; i++) chk1($sformatf("order%0d", i), glog[i], eo[i][0]);

    set_dm(0, 17, 0); step();
    if_req = 1; if_addr = 8; run(10);
    chk("busy_ign_if_rdata", if_rdata, 32'h1234);
    chk("busy_ign_dm_rdata", dm_rdata, 99);

    set_dm(0, 8, 0); step();
    do_reset();
    run(4);
    chk("midrst_dm_rdata", dm_rdata, 32'h0);
    set_dm(0, 17, 0); run(5);
    chk("after_rst_rdata", dm_rdata, 99);

    repeat (400) begin
      if (!dm_req) begin
        if ($urandom_range(0, 2) == 0) set_dm($urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        dm_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        dm_addr = $urandom_range(0, 31); dm_wdata = $urandom;
      end
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom_range(0, 31); end
      end else if ($urandom_range(0, 19) == 0) begin
        if_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        if_addr = $urandom_range(0, 31);
      end
      step();
    end
    dm_req = 0; if_req = 0;
    run(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port `memory` block between the instruction-fetch requester (if_*) and the load/store requester (dm_*) of the MIPS core.
- Accepts one request at a time and registers its address, data and direction.
- Drives the memory strobes for a fixed number of cycles, then returns read data or a write acknowledge to the granted requester.
- Sits between the core pipeline and `memory`; all data widths come from `WIDTH` in memory.vh.

Parameters:
- MEM_LATENCY, 1: cycles the memory strobes are held per access; legal values >= 1.
- CNT_W, 4: width of the access cycle counter; must hold MEM_LATENCY.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ready is seen.
- if_addr  in  WIDTH  fetch address.
- if_ready  out  1  one-cycle pulse; fetch request accepted this cycle.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  WIDTH  fetched word.
- dm_req  in  1  data request; held high until dm_ready is seen.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  WIDTH  data address.
- dm_wdata  in  WIDTH  store data.
- dm_ready  out  1  one-cycle pulse; data request accepted this cycle.
- dm_valid  out  1  one-cycle pulse; load data is valid or the store is complete.
- dm_rdata  out  WIDTH  loaded word.
- memory_read  out  1  to memory read enable.
- memory_write  out  1  to memory write enable.
- memory_address  out  WIDTH  to memory address.
- memory_data_write  out  WIDTH  to memory write data.
- memory_data_read  in  WIDTH  from memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (rst_n low at a clock edge): state=IDLE, counter=0, all strobes/ready/valid=0, memory_address=0, memory_data_write=0, if_rdata=0, dm_rdata=0, grant owner=none.
- States are IDLE -> ACCESS -> RESPOND -> IDLE.
- IDLE:
  - If any request is high, select one per the arbitration rule.
  - Assert the winner's *_ready combinationally in this cycle (cycle N).
  - At the edge, latch the winner's address, wdata and we, record the owner, set counter=MEM_LATENCY-1, and go to ACCESS.
  - The loser's ready stays low; its request remains pending.
  - With no request, stay in IDLE.
- ACCESS:
  - memory_address and memory_data_write come from registers.
  - memory_read = !we_reg and memory_write = we_reg, held for MEM_LATENCY cycles (N+1 .. N+MEM_LATENCY).
  - Each cycle, decrement the counter.
  - When counter==0: on that edge capture memory_data_read into the owner's rdata register (loads only; stores leave rdata unchanged), then go to RESPOND.
- RESPOND:
  - Pulse the owner's *_valid for one cycle (cycle N+MEM_LATENCY+1).
  - Strobes are low; go to IDLE.
  - A new grant is possible in the following cycle; peak throughput is one access per MEM_LATENCY+2 cycles.
- Strobe rules:
  - memory_read and memory_write are never high together.
  - Both are low outside ACCESS.
- Arbitration with the option out: fixed priority, dm over if.
- Simultaneous requests: exactly one ready pulses; the other is granted on a later IDLE visit.
- Requests arriving while not in IDLE are ignored (no ready) until IDLE.
- Requester obligations:
  - A requester that drops req before its ready pulse is simply not served.
  - Changing addr/wdata while ready is low is legal; values are sampled only at the accepting edge.
- *_rdata holds its last value until the next load for that requester.
- Reset mid-transaction: strobes drop on the reset edge, no *_valid is issued, and the transaction is discarded.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration: a last_owner register (reset value = if) gives priority to the requester not served last.
  - With continuous simultaneous requests, grants alternate dm, if, dm, if...
- Undefined:
  - Fixed dm-over-if priority.
  - last_owner is not implemented.

Test Plan:
- Load (MEM_LATENCY=2): preload addr 8 with 32'h1234 via dm store; then dm_req, dm_we=0, dm_addr=8 -> dm_ready in cycle N, memory_read high N+1..N+2, dm_valid at N+3 with dm_rdata=32'h1234.
- Store: dm_we=1, dm_addr=17, dm_wdata=99 -> memory_write high for exactly 2 cycles with address 17 and data 99, memory_read low throughout, dm_valid at N+3; a subsequent if fetch of addr 17 returns 99.
- Contention, option off: if_req and dm_req both held high -> dm granted first; if_ready pulses in the first IDLE after dm_valid; if_valid follows 3 cycles later.
- Contention, MEM_ARB_RR_EN defined: both requests held for 4 grants -> grant order dm, if, dm, if.
- Reset mid-ACCESS: assert rst_n=0 for 1 cycle during the first ACCESS cycle -> strobes and busy low on the next edge, no *_valid pulse; the next request completes normally.
- Busy ignore: if_req rises during dm ACCESS -> no if_ready until state returns to IDLE; if_valid correct afterwards.
